// File: rtl/load_store_unit.sv
// load_store_unit: sub-word load/store sequencer in front of Data_Memory.
// One access in flight at a time. Sub-word stores are done as a read-modify-write
// of the containing 32-bit word. Loads are lane-extracted and then sign- or zero-extended.
module load_store_unit #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // The range bounds are compared at 33 bits so that the top of the range cannot wrap.
    localparam logic [32:0] LO = 33'(BASE_ADDR);
    localparam logic [32:0] HI = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);

    state_t      state, state_nx;
    logic        w_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rd_q;

    logic        accept, err_in;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data, merged;

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // Decide at acceptance time whether the request is illegal.
    always_comb begin
        err_in = 1'b0;
        if (req_size == 2'b11)                         err_in = 1'b1;
        if (req_size == 2'b01 && req_addr[0])          err_in = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) err_in = 1'b1;
        if ({1'b0, req_addr} < LO || {1'b0, req_addr} >= HI) err_in = 1'b1;
    end

    // Extract the load lane and build the store word from the registered read data.
    always_comb begin
        byte_v = rd_q[8*addr_q[1:0] +: 8];
        half_v = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
        case (size_q)
            2'b00:   load_data = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'b01:   load_data = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_data = rd_q;
        endcase
        merged = rd_q;
        case (size_q)
            2'b00:   merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
            2'b01:   merged[16*addr_q[1] +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // State register, the request latch, and capture of the memory read word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            w_q     <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                w_q     <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= err_in;
            end
            if (state == READ) rd_q <= mem_rdata;
        end
    end

    // Next-state logic. Every output is forced low while reset is asserted.
    always_comb begin
        state_nx   = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (err_in)                              state_nx = RESP;
                    else if (req_write && req_size == 2'b10) state_nx = WRITE;
                    else                                     state_nx = READ;
                end
            end
            READ: begin
                mem_read = reset;
                mem_addr = reset ? {addr_q[31:2], 2'b00} : '0;
                state_nx = w_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = reset;
                mem_addr  = reset ? {addr_q[31:2], 2'b00} : '0;
                mem_wdata = reset ? merged : '0;
                state_nx  = RESP;
            end
            default: begin
                resp_valid = reset;
                resp_err   = reset && err_q;
                resp_rdata = (reset && !err_q && !w_q) ? load_data : '0;
                state_nx   = IDLE;
            end
        endcase
    end

endmodule
